// File: rtl/ram_stream_reader.sv
// ram_stream_reader: fetches a contiguous run of words from a sync-read RAM
// and streams them in address order on a valid/ready port through a 2-entry
// buffer. Optional feature macro: RAM_STREAM_LAST_EN adds the m_last marker.
module ram_stream_reader #(
   parameter int MEM_WIDTH = 32,
   parameter int MEM_DEPTH = 1024,
   localparam int AW = $clog2(MEM_DEPTH)
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic [AW-1:0]        base_addr,
   input  logic [AW:0]          count,
   output logic                 busy,
   output logic                 done,
   output logic                 ram_enable,
   output logic                 ram_write_en,
   output logic                 ram_reset,
   output logic [AW-1:0]        ram_address,
   input  logic [MEM_WIDTH-1:0] ram_data_out,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic [MEM_WIDTH-1:0] m_data
`ifdef RAM_STREAM_LAST_EN
   ,
   output logic                 m_last
`endif
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_DRAIN,
      S_DONE
   } state_e;

   localparam logic [AW-1:0] ADDR_MAX = AW'(MEM_DEPTH - 1);
   localparam logic [AW:0]   REM_ONE  = (AW + 1)'(1);

   state_e               state_q, state_d;
   logic [AW-1:0]        addr_q, addr_d;
   logic [AW:0]          remain_q, remain_d;
   logic                 rd_pend_q;
   logic [MEM_WIDTH-1:0] fifo_q [2];
   logic                 wr_ptr_q, rd_ptr_q;
   logic [1:0]           cnt_q, cnt_d;
   logic                 push, pop, issue;
   logic [2:0]           occ;

`ifdef RAM_STREAM_LAST_EN
   logic                 pend_last_q;
   logic                 last_q [2];
`endif

   // Buffer occupancy after this cycle's pop decides whether a read may issue.
   always_comb begin
      push  = rd_pend_q;
      pop   = (cnt_q != 2'd0) & m_ready;
      occ   = {1'b0, cnt_q} + {2'b0, rd_pend_q} - {2'b0, pop};
      issue = (state_q == S_FETCH) && (remain_q != '0) && (occ < 3'd2);
      cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
   end

   // Next-state logic for the transfer sequencer and its address/remaining counters.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      remain_d = remain_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               addr_d   = base_addr;
               remain_d = count;
               state_d  = (count == '0) ? S_DONE : S_FETCH;
            end
         end
         S_FETCH: begin
            if (issue) begin
               remain_d = remain_q - REM_ONE;
               addr_d   = (addr_q == ADDR_MAX) ? '0 : addr_q + AW'(1);
               if (remain_q == REM_ONE) state_d = S_DRAIN;
            end else if (remain_q == '0) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (pop && (cnt_q == 2'd1) && !rd_pend_q) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Sequencer state, read pointer and remaining-issue counter.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         remain_q  <= '0;
         rd_pend_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         remain_q  <= remain_d;
         rd_pend_q <= issue;
      end
   end

   // Two-entry output buffer capturing RAM data one cycle after each issue.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         fifo_q[0] <= '0;
         fifo_q[1] <= '0;
         wr_ptr_q  <= 1'b0;
         rd_ptr_q  <= 1'b0;
         cnt_q     <= 2'd0;
      end else begin
         if (push) begin
            fifo_q[wr_ptr_q] <= ram_data_out;
            wr_ptr_q         <= ~wr_ptr_q;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;
         cnt_q <= cnt_d;
      end
   end

`ifdef RAM_STREAM_LAST_EN
   // Last-word flag follows its word from issue through the buffer.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pend_last_q <= 1'b0;
         last_q[0]   <= 1'b0;
         last_q[1]   <= 1'b0;
      end else begin
         pend_last_q <= issue && (remain_q == REM_ONE);
         if (push) last_q[wr_ptr_q] <= pend_last_q;
      end
   end

   assign m_last = m_valid & last_q[rd_ptr_q];
`endif

   assign busy         = (state_q == S_FETCH) || (state_q == S_DRAIN);
   assign done         = (state_q == S_DONE);
   assign ram_enable   = issue;
   assign ram_write_en = 1'b0;
   assign ram_reset    = 1'b0;
   assign ram_address  = addr_q;
   assign m_valid      = (cnt_q != 2'd0);
   assign m_data       = fifo_q[rd_ptr_q];

endmodule

// File: tb/tb_ram_stream_reader.sv
// Randomized scoreboard bench for ram_stream_reader with a behavioural RAM.
// Expected words come from the bench's own memory image and transfer rules.
module tb_ram_stream_reader;

   localparam int MW = 32;
   localparam int MD = 16;
   localparam int AW = 4;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [AW:0]   count = '0;
   logic          busy, done, ram_enable, ram_write_en, ram_reset;
   logic [AW-1:0] ram_address;
   logic [MW-1:0] ram_data_out;
   logic          m_valid;
   logic          m_ready = 1'b0;
   logic [MW-1:0] m_data;
`ifdef RAM_STREAM_LAST_EN
   logic          m_last;
`endif

   ram_stream_reader #(.MEM_WIDTH(MW), .MEM_DEPTH(MD)) dut (
      .clock(clock), .reset_n(reset_n), .start(start),
      .base_addr(base_addr), .count(count), .busy(busy), .done(done),
      .ram_enable(ram_enable), .ram_write_en(ram_write_en),
      .ram_reset(ram_reset), .ram_address(ram_address),
      .ram_data_out(ram_data_out), .m_valid(m_valid), .m_ready(m_ready),
      .m_data(m_data)
`ifdef RAM_STREAM_LAST_EN
      , .m_last(m_last)
`endif
   );

   always #5 clock = ~clock;

   // Behavioural single-port RAM with one-cycle read latency; holds output.
   logic [MW-1:0] mem [MD];
   logic [MW-1:0] ram_q = '0;
   always @(posedge clock) if (ram_enable) ram_q <= mem[ram_address];
   assign ram_data_out = ram_q;

   int n_chk = 0;
   int n_fail = 0;
   int n_iss = 0;
   int n_pop = 0;
   logic [MW-1:0] exp_q [$];
   bit            exp_l [$];
   logic [AW-1:0] exp_addr = '0;
   int rdy_mode = 0;
   int pat_i = 0;
   bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Downstream ready generator: always-on, fixed pattern, or random.
   always @(posedge clock) begin
      #1;
      case (rdy_mode)
         0: m_ready = 1'b1;
         1: begin
            m_ready = pat[pat_i];
            pat_i = (pat_i + 1) % 6;
         end
         default: m_ready = 1'($urandom_range(0, 1));
      endcase
   end

   // Monitor: pops expected words on each handshake and checks issue rules.
   always @(negedge clock) begin
      if (reset_n) begin
         int occ;
         int pp;
         occ = n_iss - n_pop;
         pp = (m_valid && m_ready) ? 1 : 0;
         chk("ram_we_rst", {62'd0, ram_write_en, ram_reset}, 64'd0);
         if (ram_enable) begin
            chk("issue_room", 64'((occ - pp) < 2), 64'd1);
            chk("ram_addr", 64'(ram_address), 64'(exp_addr));
            exp_addr = AW'((int'(exp_addr) + 1) % MD);
            n_iss++;
         end
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_word", 64'(m_data), 64'hx_dead);
            end else begin
               chk("m_data", 64'(m_data), 64'(exp_q.pop_front()));
`ifdef RAM_STREAM_LAST_EN
               chk("m_last", 64'(m_last), 64'(exp_l.pop_front()));
`else
               void'(exp_l.pop_front());
`endif
            end
            n_pop++;
         end
      end
   end

   task automatic chk_all_zero(input string nm);
      chk({nm, "_busy"}, 64'(busy), 64'd0);
      chk({nm, "_done"}, 64'(done), 64'd0);
      chk({nm, "_en"}, 64'(ram_enable), 64'd0);
      chk({nm, "_we"}, 64'(ram_write_en), 64'd0);
      chk({nm, "_rrst"}, 64'(ram_reset), 64'd0);
      chk({nm, "_addr"}, 64'(ram_address), 64'd0);
      chk({nm, "_valid"}, 64'(m_valid), 64'd0);
      chk({nm, "_data"}, 64'(m_data), 64'd0);
`ifdef RAM_STREAM_LAST_EN
      chk({nm, "_last"}, 64'(m_last), 64'd0);
`endif
   endtask

   // One transfer: start in cycle 0, watch until done; optional busy-start
   // poke and optional reset after a number of accepted words.
   task automatic run_xfer(input int b, input int n, input int mode,
                           input bit poke, input int abort_after);
      int first_en, first_v, done_k, pop0;
      rdy_mode = mode;
      pat_i = 0;
      @(posedge clock);
      #1;
      base_addr = AW'(b);
      count = (AW + 1)'(n);
      start = 1'b1;
      exp_addr = AW'(b);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(mem[(b + i) % MD]);
         exp_l.push_back(i == n - 1);
      end
      pop0 = n_pop;
      @(posedge clock);
      #1;
      start = 1'b0;
      base_addr = AW'($urandom);
      count = (AW + 1)'($urandom_range(1, MD));
      first_en = -1;
      first_v = -1;
      done_k = -1;
      for (int k = 1; k < 300 && done_k < 0; k++) begin
         @(negedge clock);
         #2;
         if (ram_enable && first_en < 0) first_en = k;
         if (m_valid && first_v < 0) first_v = k;
         if (k == 1 && n > 0) chk("busy_c1", 64'(busy), 64'd1);
         if (poke && k == 2) begin
            start = 1'b1;
            base_addr = AW'(b + 3);
            count = (AW + 1)'(3);
         end
         if (poke && k == 3) start = 1'b0;
         if (abort_after >= 0 && (n_pop - pop0) >= abort_after) begin
            reset_n = 1'b0;
            #1;
            chk_all_zero("mid_reset");
            exp_q.delete();
            exp_l.delete();
            n_iss = n_pop;
            @(posedge clock);
            #1;
            reset_n = 1'b1;
            return;
         end
         if (done) done_k = k;
      end
      if (done_k < 0) begin
         chk("done_timeout", 64'd0, 64'd1);
      end else begin
         chk("word_count", 64'(n_pop - pop0), 64'(n));
         chk("sb_empty", 64'(exp_q.size()), 64'd0);
         chk("busy_at_done", 64'(busy), 64'd0);
         if (mode == 0) begin
            if (n > 0) begin
               chk("first_en_cycle", 64'(first_en), 64'd1);
               chk("first_valid_cycle", 64'(first_v), 64'd3);
               chk("done_cycle", 64'(done_k), 64'(n + 3));
            end else begin
               chk("zero_done_cycle", 64'(done_k), 64'd1);
               chk("zero_no_en", 64'(first_en), -64'sd1);
               chk("zero_no_valid", 64'(first_v), -64'sd1);
            end
         end
      end
   endtask

   initial begin
      foreach (mem[i]) mem[i] = $urandom;
      mem[0] = 32'h3f16bb98;
      mem[1] = 32'h3eb4bc6a;
      mem[2] = 32'h3e41f212;
      mem[3] = 32'h3f820c49;
      mem[5] = 32'h3e820c49;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk_all_zero("reset");
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      run_xfer(0, 4, 0, 1'b0, -1);
      run_xfer(2, 6, 1, 1'b0, -1);
      run_xfer(14, 4, 0, 1'b0, -1);
      run_xfer(9, 0, 0, 1'b0, -1);
      run_xfer(3, 8, 0, 1'b0, 2);
      run_xfer(5, 1, 0, 1'b0, -1);
      run_xfer(7, 8, 0, 1'b1, -1);
      run_xfer(10, 9, 2, 1'b1, -1);
      run_xfer(0, 16, 0, 1'b0, -1);
      for (int t = 0; t < 25; t++) begin
         int rb, rn, rm;
         rb = $urandom_range(0, MD - 1);
         rn = $urandom_range(0, MD);
         rm = $urandom_range(0, 2);
         run_xfer(rb, rn, rm, (rn >= 6) && ($urandom_range(0, 1) == 1), -1);
      end
      repeat (3) @(posedge clock);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ram_stream_reader.md
# ram_stream_reader

Sequencer that sits directly in front of a single-port synchronous-read parameter RAM. It drives the RAM's enable and address ports to fetch a contiguous run of words, and absorbs the RAM's one-cycle read latency. It presents the words in order on a valid/ready stream to the downstream arithmetic datapath, sustaining one word per cycle with full backpressure support through a 2-entry output buffer. It only reads the RAM: write-enable and output-reset to the RAM are held low.

## Interface
- MEM_WIDTH, 32, data word width (matches the RAM).
- MEM_DEPTH, 1024, RAM depth in words; need not be a power of two.
- AW (localparam), $clog2(MEM_DEPTH), address width.
- clock  in  1  rising-edge clock for all state.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request pulse; sampled only when busy=0.
- base_addr  in  AW  first word address, latched on accepted start.
- count  in  AW+1  number of words to stream, 0..MEM_DEPTH, latched on accepted start.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse after the final word is accepted.
- ram_enable  out  1  to RAM enable.
- ram_write_en  out  1  to RAM write enable; constant 0.
- ram_reset  out  1  to RAM output reset; constant 0.
- ram_address  out  AW  to RAM address.
- ram_data_out  in  MEM_WIDTH  from RAM read data.
- m_valid  out  1  stream word valid.
- m_ready  in  1  downstream accepts the word.
- m_data  out  MEM_WIDTH  stream word.
- m_last  out  1  final word marker; present only with RAM_STREAM_LAST_EN.

## Operation
- States:
  - IDLE to FETCH on start with count>0.
  - IDLE to DONE on start with count=0.
  - FETCH to DRAIN when remaining issues reach 0.
  - DRAIN to DONE when the last word handshakes (m_valid & m_ready) with buffer empty and no read pending.
  - DONE to IDLE unconditionally after 1 cycle.
- busy=1 in FETCH and DRAIN. done=1 only in DONE. start is ignored while busy=1 and also in DONE.
- Issue rule: ram_enable = FETCH & remaining>0 & (fifo_count + rd_pending − pop) < 2.
  - pop = m_valid & m_ready, evaluated combinationally in the same cycle.
  - This guarantees the buffer never overflows and allows 1 word/cycle when m_ready is held high.
- rd_pending is set on the edge where ram_enable=1 and cleared otherwise.
- While rd_pending=1, ram_data_out is valid and is pushed into the buffer at the next edge. The RAM holds its output when not enabled, so stalls never corrupt data.
- ram_address is a registered pointer:
  - Loaded with base_addr on start.
  - Incremented after each issue; wraps from MEM_DEPTH−1 to 0.
- Buffer is a 2-entry FIFO:
  - m_data is the head entry; m_valid = (fifo_count≠0).
  - Simultaneous push and pop at count 2 cannot occur, because the issue rule prevents it.
  - Simultaneous push and pop at count 1 keeps count at 1.
- Words leave in exact address order, with no drops or duplicates.
- reset_n low at any time, including mid-stream:
  - State returns to IDLE; buffer, rd_pending and counters are cleared.
  - The transfer is abandoned. RAM contents are unaffected.

## Timing
- Reset values: busy=0, done=0, ram_enable=0, ram_write_en=0, ram_reset=0, ram_address=0, m_valid=0, m_data=0, m_last=0.
- start high in cycle 0: ram_enable first high in cycle 1, data returns in cycle 2, m_valid first high in cycle 3.
- With m_ready=1 throughout, N words occupy cycles 3..N+2, done=1 in cycle N+3, and busy falls in cycle N+3.
- count=0: done=1 in cycle 1 (busy stays 0); no ram_enable, no m_valid.
- A new start is accepted in the first IDLE cycle after done.

## Configuration
- RAM_STREAM_LAST_EN defined:
  - The m_last port exists. A last flag is stored alongside each buffered word.
  - m_last=1 only when the head word is the final word of the transfer; it is qualified by m_valid.
- RAM_STREAM_LAST_EN undefined: no m_last port and no flag storage; all other behaviour is identical.

## Test plan
- Streaming: RAM preloaded with ram[0..3]=3f16bb98,3eb4bc6a,3e41f212,3f820c49; start base 0, count 4, m_ready=1 → m_data presents those 4 values in cycles 3–6, done in cycle 7, ram_write_en never 1.
- Backpressure: count 6, m_ready pattern 1,0,0,1,0,1,… → exactly 6 handshakes in address order; ram_enable never 1 when fifo_count+rd_pending−pop=2.
- Wrap-around: MEM_DEPTH=16, base 14, count 4 → ram_address sequence 14,15,0,1; 4 correct words.
- Zero length: count 0 → done in cycle 1, ram_enable and m_valid stay 0 throughout.
- Reset mid-stream: reset_n low after 2 of 8 words accepted → all outputs 0 immediately. After release, start base 5, count 1 → single word 3e820c49, then done.
- start while busy, with RAM_STREAM_LAST_EN: start pulsed during FETCH → ignored, word count unchanged; m_last=1 only with the final word.
